axi_wr_master: RTL

- AXI4 write-channel initiator: the mirror of the write side of axi2apb_bridge.
- Accepts a burst descriptor (address, length, ID) and a stream of data words, then issues AW, streams W beats with wlast, waits for B, and reports completion.
- Sits between the core's store path and the bridge's aw*/w*/b* slave ports.

---
 rtl/axi_pkg.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/axi_wr_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/response constants and write FSM state type
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags and register-array head output
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & !full;
    assign do_pop   = pop & !empty;
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_master.sv
// rtl/axi_wr_master.sv - AXI4 write initiator (AW/W/B); B watchdog enabled by AXI_WR_TIMEOUT_EN
module axi_wr_master
    import axi_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int MAX_LEN        = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [7:0]          req_len,
    input  logic [ID_W-1:0]     req_id,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    output logic                done_valid,
    output logic [1:0]          done_resp,
    output logic [ID_W-1:0]     done_id,
    output logic                done_err,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [ID_W-1:0]     awid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    input  logic [ID_W-1:0]     bid
);

    localparam logic [2:0] AW_SIZE = 3'($clog2(DATA_W / 8));

    wr_state_t         state;
    wr_state_t         state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        beat_cnt;
    logic              aw_done;
    logic              w_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              req_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              burst_fin;
    logic              tmo_hit;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wd_valid),
        .push_data (wd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wd_ready = !fifo_full;
    assign req_hs   = req_valid & req_ready;
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign b_hs     = bvalid & bready;
    assign fifo_pop = w_hs;

    // Address and data phases may finish in either order or together
    assign burst_fin = (aw_done | aw_hs) & (w_done | (w_hs & wlast));

    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awid    = id_q;
    assign awsize  = AW_SIZE;
    assign awburst = BURST_INCR;
    assign wdata   = fifo_dout;
    assign wstrb   = '1;
    assign wlast   = wvalid & (beat_cnt == 8'd0);

`ifdef AXI_WR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Watchdog: counts cycles spent waiting for B, restarts on every RESP entry
    always_ff @(posedge clk) begin
        if (rst || state != RESP) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == RESP) && !bvalid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: one outstanding burst from request to response
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_hs) state_nx = BURST;
            BURST:   if (burst_fin) state_nx = RESP;
            RESP:    if (b_hs || tmo_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs per state; request is refused while reset is applied
    always_comb begin
        req_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = !rst;
            end
            BURST: begin
                awvalid = !aw_done;
                wvalid  = !w_done & !fifo_empty;
            end
            RESP: begin
                bready = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Burst descriptor latch, beat countdown and per-channel completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else if (req_hs) begin
            addr_q   <= req_addr;
            len_q    <= req_len;
            id_q     <= req_id;
            beat_cnt <= req_len;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                if (wlast) begin
                    w_done <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt - 1'b1;
                end
            end
        end
    end

    // Registered completion report, one cycle after the B handshake or watchdog expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            done_valid <= 1'b0;
            done_resp  <= RESP_OKAY;
            done_id    <= '0;
            done_err   <= 1'b0;
        end else begin
            done_valid <= b_hs | tmo_hit;
            done_resp  <= b_hs ? bresp : (tmo_hit ? RESP_SLVERR : RESP_OKAY);
            done_id    <= (b_hs | tmo_hit) ? id_q : '0;
            done_err   <= b_hs ? (bid != id_q) : tmo_hit;
        end
    end

    // Caller contract: burst length within MAX_LEN, watchdog limit meaningful
    always_ff @(posedge clk) begin
        if (!rst && req_hs) begin
            assert (int'(req_len) < MAX_LEN);
            assert (TIMEOUT_CYCLES >= 2);
        end
    end

endmodule
